// File: rtl/fmac_mul_arb.sv
// rtl/fmac_mul_arb.sv - two-requester round-robin front end and output stage for a shared mantissa multiplier tree
//
// Purpose:
//   Two requesters share one external partial-product generator / Wallace tree.
//   A round-robin arbiter picks one operand pair per cycle into stage S1, whose
//   registers drive the tree. Stage S2 captures the tree's redundant sum/carry
//   vectors together with the tag and source port. The final carry-propagate
//   add happens combinationally on the S2 registers.
//
// Ports:
//   Clk_CI                     clock, rising edge
//   Rst_RBI                    asynchronous active-low reset
//   In0_/In1_Valid_SI          requester has an operand pair
//   In0_/In1_Ready_SO          requester's pair is accepted this cycle
//   In0_/In1_OpA_DI, _OpB_DI   mantissas including hidden bit (W = C_MANT+1)
//   In0_/In1_Tag_DI            requester tag
//   Tree_OpA_DO, Tree_OpB_DO   S1 operand registers to the tree
//   Tree_Sum_DI, Tree_Carry_DI tree outputs (2W+1 bits) for the S1 operands
//   Out_Valid_SO/Out_Ready_SI  product handshake
//   Out_Prod_DO                2W-bit product
//   Out_Tag_DO, Out_Src_SO     tag and originating port of the product
//   Busy_SO                    any stage holds an operation

module fmac_mul_arb #(
    parameter int C_MANT = 23,
    parameter int C_TAG  = 4
) (
    input  logic                  Clk_CI,
    input  logic                  Rst_RBI,

    input  logic                  In0_Valid_SI,
    output logic                  In0_Ready_SO,
    input  logic [C_MANT:0]       In0_OpA_DI,
    input  logic [C_MANT:0]       In0_OpB_DI,
    input  logic [C_TAG-1:0]      In0_Tag_DI,

    input  logic                  In1_Valid_SI,
    output logic                  In1_Ready_SO,
    input  logic [C_MANT:0]       In1_OpA_DI,
    input  logic [C_MANT:0]       In1_OpB_DI,
    input  logic [C_TAG-1:0]      In1_Tag_DI,

    output logic [C_MANT:0]       Tree_OpA_DO,
    output logic [C_MANT:0]       Tree_OpB_DO,
    input  logic [2*C_MANT+2:0]   Tree_Sum_DI,
    input  logic [2*C_MANT+2:0]   Tree_Carry_DI,

    output logic                  Out_Valid_SO,
    input  logic                  Out_Ready_SI,
    output logic [2*C_MANT+1:0]   Out_Prod_DO,
    output logic [C_TAG-1:0]      Out_Tag_DO,
    output logic                  Out_Src_SO,

    output logic                  Busy_SO
);

    localparam int W  = C_MANT + 1;
    localparam int PW = 2 * W;

    // Stage S1: operands feeding the tree
    logic                 r_s1_valid;
    logic [W-1:0]         r_s1_opa;
    logic [W-1:0]         r_s1_opb;
    logic [C_TAG-1:0]     r_s1_tag;
    logic                 r_s1_src;

    // Stage S2: redundant product, only the bits that reach the final add
    logic                 r_s2_valid;
    logic [PW-1:0]        r_s2_sum;
    logic [PW-2:0]        r_s2_carry;
    logic [C_TAG-1:0]     r_s2_tag;
    logic                 r_s2_src;

    // Arbiter state
    logic                 r_ptr;        // port favoured when both request
    logic                 r_lock;       // a granted request is still waiting
    logic                 r_lock_port;  // which port that waiting request is on

    logic                 w_s2_load;
    logic                 w_s1_ready;
    logic                 w_any_valid;
    logic                 w_grant;
    logic                 w_accept;
    logic [W-1:0]         w_sel_opa;
    logic [W-1:0]         w_sel_opb;
    logic [C_TAG-1:0]     w_sel_tag;

    // The top bit of each tree vector has weight 2^(2W) (or more once the
    // carry is shifted), so it never affects the 2W-bit product.
    logic                 w_unused_tree_msbs;
    assign w_unused_tree_msbs = ^{Tree_Sum_DI[PW], Tree_Carry_DI[PW:PW-1]};

    // Pipeline advance conditions
    assign w_s2_load  = r_s1_valid & (~r_s2_valid | Out_Ready_SI);
    assign w_s1_ready = ~r_s1_valid | w_s2_load;

    // Grant selection. A request that was granted but could not be accepted
    // keeps the grant while it stays valid, so a late-arriving request on the
    // other port cannot steal a grant that has already been offered.
    assign w_any_valid = In0_Valid_SI | In1_Valid_SI;

    always_comb begin
        w_grant = 1'b0;
        if (r_lock && (r_lock_port ? In1_Valid_SI : In0_Valid_SI)) begin
            w_grant = r_lock_port;
        end else if (In0_Valid_SI && In1_Valid_SI) begin
            w_grant = r_ptr;
        end else begin
            w_grant = In1_Valid_SI;
        end
    end

    assign w_accept = w_any_valid & w_s1_ready & Rst_RBI;

    // Ready is gated by reset directly: S1 is empty during reset and would
    // otherwise advertise readiness, yet a request must still be acceptable
    // on the very first edge after release.
    assign In0_Ready_SO = Rst_RBI & w_s1_ready & In0_Valid_SI & ~w_grant;
    assign In1_Ready_SO = Rst_RBI & w_s1_ready & In1_Valid_SI &  w_grant;

    // Operand mux for the granted port
    always_comb begin
        w_sel_opa = In0_OpA_DI;
        w_sel_opb = In0_OpB_DI;
        w_sel_tag = In0_Tag_DI;
        if (w_grant) begin
            w_sel_opa = In1_OpA_DI;
            w_sel_opb = In1_OpB_DI;
            w_sel_tag = In1_Tag_DI;
        end
    end

    // Arbiter pointer and grant lock
    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            r_ptr       <= 1'b0;
            r_lock      <= 1'b0;
            r_lock_port <= 1'b0;
        end else begin
            if (w_accept) begin
                r_ptr  <= ~w_grant;
                r_lock <= 1'b0;
            end else if (w_any_valid) begin
                r_lock      <= 1'b1;
                r_lock_port <= w_grant;
            end else begin
                r_lock <= 1'b0;
            end
        end
    end

    // Stage S1
    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            r_s1_valid <= 1'b0;
            r_s1_opa   <= '0;
            r_s1_opb   <= '0;
            r_s1_tag   <= '0;
            r_s1_src   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_s1_valid <= 1'b1;
                r_s1_opa   <= w_sel_opa;
                r_s1_opb   <= w_sel_opb;
                r_s1_tag   <= w_sel_tag;
                r_s1_src   <= w_grant;
            end else if (w_s2_load) begin
                r_s1_valid <= 1'b0;
            end
        end
    end

    // Stage S2: holds everything while the consumer stalls
    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            r_s2_valid <= 1'b0;
            r_s2_sum   <= '0;
            r_s2_carry <= '0;
            r_s2_tag   <= '0;
            r_s2_src   <= 1'b0;
        end else begin
            if (w_s2_load) begin
                r_s2_valid <= 1'b1;
                r_s2_sum   <= Tree_Sum_DI[PW-1:0];
                r_s2_carry <= Tree_Carry_DI[PW-2:0];
                r_s2_tag   <= r_s1_tag;
                r_s2_src   <= r_s1_src;
            end else if (Out_Ready_SI) begin
                r_s2_valid <= 1'b0;
            end
        end
    end

    assign Tree_OpA_DO  = r_s1_opa;
    assign Tree_OpB_DO  = r_s1_opb;

    // Final carry-propagate add; the carry vector carries weight 2
    assign Out_Prod_DO  = r_s2_sum + {r_s2_carry, 1'b0};
    assign Out_Valid_SO = r_s2_valid;
    assign Out_Tag_DO   = r_s2_tag;
    assign Out_Src_SO   = r_s2_src;

    assign Busy_SO      = r_s1_valid | r_s2_valid;

endmodule

// File: tb/tb_fmac_mul_arb.sv
// tb/tb_fmac_mul_arb.sv - self-checking bench for fmac_mul_arb with scoreboard and tree model

module tb_fmac_mul_arb;

    localparam int C_MANT = 23;
    localparam int C_TAG  = 4;
    localparam int W      = C_MANT + 1;
    localparam int PW     = 2 * W;
    localparam int TW     = PW + 1;

    logic              Clk_CI = 1'b0;
    logic              Rst_RBI = 1'b0;
    logic              In0_Valid_SI = 1'b0, In1_Valid_SI = 1'b0;
    logic              In0_Ready_SO, In1_Ready_SO;
    logic [W-1:0]      In0_OpA_DI = '0, In0_OpB_DI = '0, In1_OpA_DI = '0, In1_OpB_DI = '0;
    logic [C_TAG-1:0]  In0_Tag_DI = '0, In1_Tag_DI = '0;
    logic [W-1:0]      Tree_OpA_DO, Tree_OpB_DO;
    logic [TW-1:0]     Tree_Sum_DI, Tree_Carry_DI;
    logic              Out_Valid_SO;
    logic              Out_Ready_SI = 1'b0;
    logic [PW-1:0]     Out_Prod_DO;
    logic [C_TAG-1:0]  Out_Tag_DO;
    logic              Out_Src_SO;
    logic              Busy_SO;

    fmac_mul_arb #(.C_MANT(C_MANT), .C_TAG(C_TAG)) dut (
        .Clk_CI        (Clk_CI),
        .Rst_RBI       (Rst_RBI),
        .In0_Valid_SI  (In0_Valid_SI),
        .In0_Ready_SO  (In0_Ready_SO),
        .In0_OpA_DI    (In0_OpA_DI),
        .In0_OpB_DI    (In0_OpB_DI),
        .In0_Tag_DI    (In0_Tag_DI),
        .In1_Valid_SI  (In1_Valid_SI),
        .In1_Ready_SO  (In1_Ready_SO),
        .In1_OpA_DI    (In1_OpA_DI),
        .In1_OpB_DI    (In1_OpB_DI),
        .In1_Tag_DI    (In1_Tag_DI),
        .Tree_OpA_DO   (Tree_OpA_DO),
        .Tree_OpB_DO   (Tree_OpB_DO),
        .Tree_Sum_DI   (Tree_Sum_DI),
        .Tree_Carry_DI (Tree_Carry_DI),
        .Out_Valid_SO  (Out_Valid_SO),
        .Out_Ready_SI  (Out_Ready_SI),
        .Out_Prod_DO   (Out_Prod_DO),
        .Out_Tag_DO    (Out_Tag_DO),
        .Out_Src_SO    (Out_Src_SO),
        .Busy_SO       (Busy_SO)
    );

    always #5 Clk_CI = ~Clk_CI;

    function automatic logic [PW-1:0] mul(input logic [W-1:0] a, input logic [W-1:0] b);
        mul = PW'(a) * PW'(b);
    endfunction

    // Tree model: redundant form with an operand-dependent carry vector (top
    // bits included) so that only sum[2W-1:0] + 2*carry[2W-2:0] gives A*B.
    logic [PW-1:0] m_prod;
    always_comb begin
        m_prod        = mul(Tree_OpA_DO, Tree_OpB_DO);
        Tree_Carry_DI = {Tree_OpA_DO ^ Tree_OpB_DO, Tree_OpB_DO, 1'b1};
        Tree_Sum_DI   = {1'b0, m_prod} - {Tree_Carry_DI[PW-1:0], 1'b0};
    end

    typedef struct packed {
        logic [PW-1:0]    prod;
        logic [C_TAG-1:0] tag;
        logic             src;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_out    = 0;
    logic exp_ptr  = 1'b0;

    // Scoreboard: push on input handshake, pop and compare on output handshake
    always @(negedge Clk_CI) begin
        if (Rst_RBI) begin
            if (Out_Valid_SO && Out_Ready_SI) begin
                n_out++;
                n_checks++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_extra: got prod=%h tag=%h src=%0d, required no product", Out_Prod_DO, Out_Tag_DO, Out_Src_SO);
                end else begin
                    mon_e = q.pop_front();
                    if ({Out_Prod_DO, Out_Tag_DO, Out_Src_SO} !== mon_e) begin
                        n_fail++;
                        $display("FAIL sb_data: got prod=%h tag=%h src=%0d, required prod=%h tag=%h src=%0d",
                                 Out_Prod_DO, Out_Tag_DO, Out_Src_SO, mon_e.prod, mon_e.tag, mon_e.src);
                    end
                end
            end
            if (In0_Valid_SI && In0_Ready_SO) begin
                q.push_back({mul(In0_OpA_DI, In0_OpB_DI), In0_Tag_DI, 1'b0});
                exp_ptr = 1'b1;
            end
            if (In1_Valid_SI && In1_Ready_SO) begin
                q.push_back({mul(In1_OpA_DI, In1_OpB_DI), In1_Tag_DI, 1'b1});
                exp_ptr = 1'b0;
            end
        end
    end

    task automatic step;
        @(posedge Clk_CI);
        #1;
    endtask

    task automatic rand_port0;
        In0_OpA_DI = {1'b1, C_MANT'($urandom)};
        In0_OpB_DI = {1'b1, C_MANT'($urandom)};
        In0_Tag_DI = C_TAG'($urandom);
    endtask

    task automatic rand_port1;
        In1_OpA_DI = {1'b1, C_MANT'($urandom)};
        In1_OpB_DI = {1'b1, C_MANT'($urandom)};
        In1_Tag_DI = C_TAG'($urandom);
    endtask

    // Called just after a rising edge; empties the pipeline
    task automatic drain(input string name);
        int i;
        In0_Valid_SI = 1'b0;
        In1_Valid_SI = 1'b0;
        Out_Ready_SI = 1'b1;
        i = 0;
        while ((q.size() != 0 || Busy_SO !== 1'b0) && i < 20) begin
            step();
            i++;
        end
        n_checks++;
        if (q.size() != 0 || Busy_SO !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_drain: pending=%0d busy=%b, required pending=0 busy=0", name, q.size(), Busy_SO);
        end
    endtask

    task automatic test_reset;
        In0_Valid_SI = 1'b1;
        In1_Valid_SI = 1'b1;
        rand_port0();
        rand_port1();
        Out_Ready_SI = 1'b1;
        repeat (3) @(negedge Clk_CI);
        n_checks++;
        if ({Out_Valid_SO, Busy_SO, In0_Ready_SO, In1_Ready_SO} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_ctrl: valid/busy/rdy0/rdy1=%b, required 0000", {Out_Valid_SO, Busy_SO, In0_Ready_SO, In1_Ready_SO});
        end
        n_checks++;
        if ({Out_Prod_DO, Out_Tag_DO, Out_Src_SO, Tree_OpA_DO, Tree_OpB_DO} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: prod=%h tag=%h opa=%h opb=%h, required all zero", Out_Prod_DO, Out_Tag_DO, Tree_OpA_DO, Tree_OpB_DO);
        end
        In0_Valid_SI = 1'b0;
        In1_Valid_SI = 1'b0;
        step();
        Rst_RBI = 1'b1;
        step();
    endtask

    task automatic test_single;
        In0_Valid_SI = 1'b1;
        In0_OpA_DI   = 24'h800000;
        In0_OpB_DI   = 24'h800000;
        In0_Tag_DI   = 4'h5;
        Out_Ready_SI = 1'b1;
        @(negedge Clk_CI);
        n_checks++;
        if (In0_Ready_SO !== 1'b1) begin
            n_fail++;
            $display("FAIL single_ready: rdy0=%b, required 1", In0_Ready_SO);
        end
        step();
        In0_Valid_SI = 1'b0;
        @(negedge Clk_CI);
        n_checks++;
        if (Out_Valid_SO !== 1'b0) begin
            n_fail++;
            $display("FAIL single_early: out_valid=%b one cycle after handshake, required 0", Out_Valid_SO);
        end
        @(negedge Clk_CI);
        n_checks++;
        if (Out_Valid_SO !== 1'b1 || Out_Prod_DO !== 48'h400000000000 || Out_Src_SO !== 1'b0) begin
            n_fail++;
            $display("FAIL single_out: valid=%b prod=%h src=%b, required 1 400000000000 0", Out_Valid_SO, Out_Prod_DO, Out_Src_SO);
        end
        step();
        drain("single");
    endtask

    task automatic test_wallace;
        In0_Valid_SI = 1'b1;
        In0_OpA_DI   = 24'hFFFFFF;
        In0_OpB_DI   = 24'hFFFFFF;
        In0_Tag_DI   = 4'hA;
        Out_Ready_SI = 1'b1;
        step();
        In0_Valid_SI = 1'b0;
        @(negedge Clk_CI);
        @(negedge Clk_CI);
        n_checks++;
        if (Out_Valid_SO !== 1'b1 || Out_Prod_DO !== 48'hFFFFFE000001 || Out_Tag_DO !== 4'hA) begin
            n_fail++;
            $display("FAIL wallace_prod: valid=%b prod=%h tag=%h, required 1 fffffe000001 a", Out_Valid_SO, Out_Prod_DO, Out_Tag_DO);
        end
        step();
        drain("wallace");
    endtask

    task automatic test_alternate;
        logic p;
        logic a0, a1;
        p = exp_ptr;
        In0_Valid_SI = 1'b1;
        In1_Valid_SI = 1'b1;
        rand_port0();
        rand_port1();
        Out_Ready_SI = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge Clk_CI);
            a0 = In0_Ready_SO;
            a1 = In1_Ready_SO;
            n_checks++;
            if ({a0, a1} !== {~p, p}) begin
                n_fail++;
                $display("FAIL alt_grant[%0d]: rdy0/rdy1=%b%b, required %b%b", c, a0, a1, ~p, p);
            end
            if (c >= 2) begin
                n_checks++;
                if (Out_Valid_SO !== 1'b1) begin
                    n_fail++;
                    $display("FAIL alt_rate[%0d]: out_valid=%b, required 1", c, Out_Valid_SO);
                end
            end
            p = ~p;
            step();
            if (a0) rand_port0();
            if (a1) rand_port1();
        end
        drain("alternate");
    endtask

    task automatic test_backpressure;
        logic [W-1:0]     first_a, first_b;
        logic [C_TAG-1:0] first_t;
        int               acc;
        logic             r0;
        acc = 0;
        Out_Ready_SI = 1'b0;
        In0_Valid_SI = 1'b1;
        rand_port0();
        first_a = In0_OpA_DI;
        first_b = In0_OpB_DI;
        first_t = In0_Tag_DI;
        for (int c = 0; c < 5; c++) begin
            @(negedge Clk_CI);
            r0 = In0_Ready_SO;
            if (r0) acc++;
            if (c >= 2) begin
                n_checks++;
                if (Out_Valid_SO !== 1'b1 || Busy_SO !== 1'b1 || Out_Prod_DO !== mul(first_a, first_b) ||
                    Out_Tag_DO !== first_t || In0_Ready_SO !== 1'b0 || In1_Ready_SO !== 1'b0) begin
                    n_fail++;
                    $display("FAIL bp_hold[%0d]: valid=%b busy=%b prod=%h tag=%h rdy=%b%b, required 1 1 %h %h 00",
                             c, Out_Valid_SO, Busy_SO, Out_Prod_DO, Out_Tag_DO, In0_Ready_SO, In1_Ready_SO,
                             mul(first_a, first_b), first_t);
                end
            end
            step();
            if (r0) rand_port0();
            if (c == 2) begin
                In1_Valid_SI = 1'b1;
                rand_port1();
            end
        end
        n_checks++;
        if (acc != 2) begin
            n_fail++;
            $display("FAIL bp_accepted: accepted=%0d, required 2", acc);
        end
        Out_Ready_SI = 1'b1;
        @(negedge Clk_CI);
        n_checks++;
        if ({In0_Ready_SO, In1_Ready_SO} !== 2'b10) begin
            n_fail++;
            $display("FAIL bp_lock: rdy0/rdy1=%b%b, required 10", In0_Ready_SO, In1_Ready_SO);
        end
        step();
        In0_Valid_SI = 1'b0;
        @(negedge Clk_CI);
        n_checks++;
        if (In1_Ready_SO !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_port1: rdy1=%b, required 1", In1_Ready_SO);
        end
        step();
        drain("backpressure");
    endtask

    task automatic test_random;
        logic a0, a1;
        for (int c = 0; c < 300; c++) begin
            @(negedge Clk_CI);
            a0 = In0_Valid_SI & In0_Ready_SO;
            a1 = In1_Valid_SI & In1_Ready_SO;
            n_checks++;
            if (In0_Ready_SO === 1'b1 && In1_Ready_SO === 1'b1) begin
                n_fail++;
                $display("FAIL rand_onehot[%0d]: rdy0/rdy1=11, required at most one", c);
            end
            step();
            if (!In0_Valid_SI || a0) begin
                In0_Valid_SI = ($urandom_range(0, 2) != 0);
                rand_port0();
            end
            if (!In1_Valid_SI || a1) begin
                In1_Valid_SI = ($urandom_range(0, 2) != 0);
                rand_port1();
            end
            Out_Ready_SI = ($urandom_range(0, 3) != 0);
        end
        step();
        drain("random");
    endtask

    task automatic test_reset_mid;
        int out0;
        Out_Ready_SI = 1'b0;
        In0_Valid_SI = 1'b1;
        rand_port0();
        step();
        rand_port0();
        step();
        In0_Valid_SI = 1'b0;
        @(negedge Clk_CI);
        n_checks++;
        if (Out_Valid_SO !== 1'b1 || Busy_SO !== 1'b1) begin
            n_fail++;
            $display("FAIL rmid_setup: valid=%b busy=%b, required 1 1", Out_Valid_SO, Busy_SO);
        end
        #2;
        Rst_RBI      = 1'b0;
        In1_Valid_SI = 1'b1;
        rand_port1();
        #1;
        n_checks++;
        if ({Out_Valid_SO, Busy_SO, In0_Ready_SO, In1_Ready_SO} !== 4'b0000) begin
            n_fail++;
            $display("FAIL rmid_clear: valid/busy/rdy0/rdy1=%b, required 0000", {Out_Valid_SO, Busy_SO, In0_Ready_SO, In1_Ready_SO});
        end
        q.delete();
        exp_ptr = 1'b0;
        @(posedge Clk_CI);
        #2;
        Rst_RBI      = 1'b1;
        Out_Ready_SI = 1'b1;
        out0         = n_out;
        @(negedge Clk_CI);
        n_checks++;
        if ({In0_Ready_SO, In1_Ready_SO} !== 2'b01) begin
            n_fail++;
            $display("FAIL rmid_first: rdy0/rdy1=%b%b, required 01", In0_Ready_SO, In1_Ready_SO);
        end
        step();
        In1_Valid_SI = 1'b0;
        drain("reset_mid");
        n_checks++;
        if (n_out - out0 != 1) begin
            n_fail++;
            $display("FAIL rmid_count: products=%0d, required 1", n_out - out0);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_wallace();
        test_alternate();
        test_backpressure();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, required completion");
        $fatal(1);
    end

endmodule
